// File: rtl/pipe_skid_reg.sv
// Elastic pipeline register: valid/ready stage with a 2-entry skid buffer and a registered in_ready.
// Optional stall counter enabled by defining PIPE_SKID_STALL_CNT_EN; otherwise stall_count is tied to 0.
module pipe_skid_reg #(
   parameter int unsigned      WIDTH       = 32,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter int unsigned      CNT_W       = 16
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] stall_count
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             main_valid, skid_valid;
   logic             acc, dep;

   // Valids are pure decodes of the state register, so every output is registered.
   assign main_valid = (state_q != EMPTY);
   assign skid_valid = (state_q == TWO);

   assign in_ready  = !skid_valid;
   assign out_valid = main_valid;
   assign out_data  = main_q;
   assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

   assign acc = in_valid & in_ready;
   assign dep = out_valid & out_ready;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= EMPTY;
         main_q  <= RESET_VALUE;
         skid_q  <= RESET_VALUE;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         // Flush wins over any transfer; an accepted beat this cycle is dropped.
         state_d = EMPTY;
         main_d  = RESET_VALUE;
         skid_d  = RESET_VALUE;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (acc) begin
                  state_d = ONE;
                  main_d  = in_data;
               end
            end
            ONE: begin
               if (acc && dep) begin
                  main_d = in_data;
               end else if (acc) begin
                  state_d = TWO;
                  skid_d  = in_data;
               end else if (dep) begin
                  state_d = EMPTY;
               end
            end
            TWO: begin
               if (dep) begin
                  state_d = ONE;
                  main_d  = skid_q;
               end
            end
            default: begin
               state_d = EMPTY;
               main_d  = RESET_VALUE;
               skid_d  = RESET_VALUE;
            end
         endcase
      end
   end

`ifdef PIPE_SKID_STALL_CNT_EN
   logic [CNT_W-1:0] stall_q, stall_d;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == {CNT_W{1'b1}}) begin
         sat_inc = v;
      end else begin
         sat_inc = v + CNT_W'(1);
      end
   endfunction

   always_comb begin
      stall_d = stall_q;
      if (out_valid && !out_ready) begin
         stall_d = sat_inc(stall_q);
      end
   end

   // Only reset clears the counter; flush deliberately leaves it alone.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stall_q <= '0;
      end else begin
         stall_q <= stall_d;
      end
   end

   assign stall_count = stall_q;
`else
   assign stall_count = '0;
`endif

endmodule
